// File: rtl/min_queue_drainer.sv
// Pop-side client for the min queue: issues single-cycle pops with a holdoff,
// buffers popped records in a small output FIFO, checks key ordering between
// pushes and supports a drain-to-empty request.
// Ports:
//   clk_i, rst_b_i          clock, synchronous active-high reset
//   enable_i, drain_req_i   continuous drain level / drain-to-empty pulse
//   min_valid_i, min_record_i, q_empty_i, push_seen_i   queue status
//   pop_o                   pop command to the queue (one cycle per pop)
//   out_valid_o, out_record_o, out_ready_i              output FIFO head
//   order_err_o, pop_cnt_o, drain_done_o, busy_o        status
module min_queue_drainer #(
  parameter int unsigned rec_wd      = 48,
  parameter int unsigned key_wd      = 16,
  parameter int unsigned ob_depth    = 4,
  parameter int unsigned ob_ptr_wd   = 2,
  parameter int unsigned holdoff_cyc = 2
) (
  input  logic              clk_i,
  input  logic              rst_b_i,
  input  logic              enable_i,
  input  logic              drain_req_i,
  input  logic              min_valid_i,
  input  logic [rec_wd-1:0] min_record_i,
  input  logic              q_empty_i,
  input  logic              push_seen_i,
  output logic              pop_o,
  output logic              out_valid_o,
  output logic [rec_wd-1:0] out_record_o,
  input  logic              out_ready_i,
  output logic              order_err_o,
  output logic [15:0]       pop_cnt_o,
  output logic              drain_done_o,
  output logic              busy_o
);

  localparam int unsigned cnt_wd  = ob_ptr_wd + 1;
  localparam int unsigned hold_wd = 4;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_hold = 2'd2;
  localparam logic [1:0] st_done = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               drain_pend_q, drain_pend_d;
  logic [hold_wd-1:0] hold_q, hold_d;
  logic               pop_q, pop_d;
  logic [15:0]        pop_cnt_q, pop_cnt_d;
  logic [key_wd-1:0]  last_key_q, last_key_d;
  logic               ref_ok_q, ref_ok_d;
  logic               order_err_q, order_err_d;
  logic               drain_done_q, drain_done_d;
  logic               busy_q, busy_d;
  logic [ob_ptr_wd-1:0] wr_ptr_q, wr_ptr_d;
  logic [ob_ptr_wd-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_wd-1:0]  count_q, count_d;
  logic [rec_wd-1:0]  mem_q [ob_depth];

  logic              do_pop;
  logic              do_read;
  logic [key_wd-1:0] key;

  assign key = min_record_i[rec_wd-1 -: key_wd];

  // Next-state, pop decision, order check and FIFO pointer logic
  always_comb begin
    state_d      = state_q;
    drain_pend_d = drain_pend_q | drain_req_i;
    hold_d       = hold_q;
    pop_d        = 1'b0;
    pop_cnt_d    = pop_cnt_q;
    last_key_d   = last_key_q;
    ref_ok_d     = ref_ok_q & ~push_seen_i;
    order_err_d  = order_err_q;
    do_pop       = 1'b0;
    // Space check uses the registered count only; a same-cycle read gives no credit.
    do_read      = (count_q != '0) & out_ready_i;

    case (state_q)
      st_idle: begin
        if (enable_i | drain_pend_q | drain_req_i) state_d = st_run;
      end
      st_run: begin
        if (min_valid_i && (count_q < cnt_wd'(ob_depth))) begin
          do_pop    = 1'b1;
          pop_d     = 1'b1;
          pop_cnt_d = pop_cnt_q + 16'd1;
          if (ref_ok_q && (key < last_key_q)) order_err_d = 1'b1;
          last_key_d = key;
          // A push in the same cycle still lets this compare run, but the
          // reference is invalidated afterwards.
          ref_ok_d   = ~push_seen_i;
          hold_d     = hold_wd'(holdoff_cyc);
          state_d    = st_hold;
        end else if (drain_pend_q & q_empty_i & ~min_valid_i) begin
          state_d = st_done;
        end else if (~enable_i & ~drain_pend_q & ~drain_req_i) begin
          state_d = st_idle;
        end
      end
      st_hold: begin
        // min_valid is ignored here so the queue can retire the popped entry.
        hold_d = hold_q - hold_wd'(1);
        if (hold_q <= hold_wd'(1)) state_d = st_run;
      end
      st_done: begin
        state_d = enable_i ? st_run : st_idle;
      end
      default: state_d = st_idle;
    endcase

    // Entering DONE consumes the pending drain; a request in the same cycle re-arms it.
    if (state_d == st_done && state_q != st_done) drain_pend_d = drain_req_i;

    drain_done_d = (state_d == st_done);
    busy_d       = (state_d != st_idle);

    wr_ptr_d = wr_ptr_q + ob_ptr_wd'(do_pop);
    rd_ptr_d = rd_ptr_q + ob_ptr_wd'(do_read);
    case ({do_pop, do_read})
      2'b10:   count_d = count_q + cnt_wd'(1);
      2'b01:   count_d = count_q - cnt_wd'(1);
      default: count_d = count_q;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_b_i) begin
      state_q      <= st_idle;
      drain_pend_q <= 1'b0;
      hold_q       <= '0;
      pop_q        <= 1'b0;
      pop_cnt_q    <= '0;
      last_key_q   <= '0;
      ref_ok_q     <= 1'b0;
      order_err_q  <= 1'b0;
      drain_done_q <= 1'b0;
      busy_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(ob_depth); i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      drain_pend_q <= drain_pend_d;
      hold_q       <= hold_d;
      pop_q        <= pop_d;
      pop_cnt_q    <= pop_cnt_d;
      last_key_q   <= last_key_d;
      ref_ok_q     <= ref_ok_d;
      order_err_q  <= order_err_d;
      drain_done_q <= drain_done_d;
      busy_q       <= busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (do_pop) mem_q[wr_ptr_q] <= min_record_i;
    end
  end

  assign pop_o        = pop_q;
  assign out_valid_o  = (count_q != '0);
  assign out_record_o = mem_q[rd_ptr_q];
  assign order_err_o  = order_err_q;
  assign pop_cnt_o    = pop_cnt_q;
  assign drain_done_o = drain_done_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/min_queue_drainer.md
# min_queue_drainer

Pop-side client for the min queue. It watches `min_valid`, issues single-cycle `pop` commands, and captures `pop_record` into a small output FIFO with a valid/ready handshake. It checks that popped keys are non-decreasing between pushes. It also supports a drain-to-empty request. It sits between the min queue's pop interface and the downstream record consumer.

## Interface
- `rec_wd`, 48, record width; must match the queue's `6*8` record.
- `key_wd`, 16, key width; key = `record[rec_wd-1 -: key_wd]`, compared unsigned.
- `ob_depth`, 4, output FIFO depth; power of two, minimum 2.
- `ob_ptr_wd`, 2, `log2(ob_depth)`.
- `holdoff_cyc`, 2, wait cycles after each pop before `min_valid` is sampled again; range 1..15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_b`  in  1  synchronous reset, active-high (1 = reset).
- `enable`  in  1  level; continuous draining while high.
- `drain_req`  in  1  pulse; pop until the queue is empty, then signal `drain_done`.
- `min_valid`  in  1  from queue; `min_record` is currently the minimum.
- `min_record`  in  rec_wd  from queue's `pop_record`.
- `q_empty`  in  1  from queue's `empty`.
- `push_seen`  in  1  pulse; an accepted push occurred in the queue this cycle.
- `pop`  out  1  to queue; registered, one cycle high per pop.
- `out_valid`  out  1  head of output FIFO valid.
- `out_record`  out  rec_wd  head record.
- `out_ready`  in  1  downstream accepts the head when high with `out_valid`.
- `order_err`  out  1  sticky; a key decreased with no intervening push.
- `pop_cnt`  out  16  records popped; wraps at 65535 to 0.
- `drain_done`  out  1  one-cycle pulse.
- `busy`  out  1  state is not IDLE.

## Operation
- **States:** IDLE, RUN, HOLD, DONE. Register `drain_pend` is set by `drain_req` in any state and cleared on entry to DONE.
- **IDLE:**
  - Go to RUN when `enable` or `drain_pend` (or `drain_req` this cycle).
- **RUN:**
  - Pop condition: `min_valid & (ob_count < ob_depth)`. When met:
    - assert `pop` next cycle;
    - write `min_record` into the FIFO;
    - increment `pop_cnt`;
    - run the order check;
    - load the hold counter with `holdoff_cyc`;
    - go to HOLD.
  - Otherwise:
    - if `drain_pend & q_empty & !min_valid`, go to DONE;
    - else if `!enable & !drain_pend`, go to IDLE;
    - else stay in RUN.
- **HOLD:**
  - Decrement the counter each cycle; `min_valid` is ignored.
  - Go to RUN on the cycle after the counter reaches 1.
  - This guarantees no double pop while the queue drops `min_valid`.
- **DONE:**
  - `drain_done` = 1 for exactly one cycle.
  - Next state is RUN if `enable`, else IDLE.
- **Order check:**
  - Keep `last_key` and `ref_ok`.
  - On each pop: if `ref_ok & key < last_key`, set `order_err`. Then `last_key <= key` and `ref_ok <= 1`.
  - `push_seen` clears `ref_ok`. If `push_seen` and a pop happen in the same cycle, the pop's compare still runs, then `ref_ok` ends 0.
  - `order_err` clears only on reset.
- **Output FIFO:**
  - Synchronous, registered pointers, `ob_ptr_wd+1`-bit count.
  - A simultaneous write and read keep the count unchanged.
  - The space check uses the registered count only; a same-cycle read gives no credit.
  - `out_record` holds the head; its value is don't-care when `out_valid` = 0.
- **`drain_req` while already DONE:** re-latches `drain_pend`; a new drain follows.
- **Reset mid-operation:**
  - Reset drops all state and discards FIFO contents.
  - A `pop` already asserted completes its cycle, then goes to 0 after the reset edge.

## Timing
- **Reset values:**
  - `pop`=0, `out_valid`=0, `out_record`=0, `order_err`=0, `pop_cnt`=0, `drain_done`=0, `busy`=0.
  - State IDLE, `ref_ok`=0, FIFO empty.
- **Pop decision at edge E** (RUN, `min_valid`=1, space available):
  - `pop`=1 during cycle E..E+1 only.
  - `out_valid`=1 from E with that record, if the FIFO was empty.
- **Pop spacing:** back-to-back pops are at least `1+holdoff_cyc` cycles apart. With the default, one pop per 3 cycles.
- **Enable/drain latency:** 1 cycle from `enable`/`drain_req` rising to RUN.
- **Drain completion:** `drain_done` asserts 1 cycle after the empty condition is sampled in RUN.
- **Output handshake:**
  - The record is transferred when `out_valid & out_ready` at the clock edge.
  - `out_valid` never drops without a transfer, except on reset.

## Test plan
1. **Basic drain:** queue holds keys 5, 9, 12, `enable`=1, `out_ready`=1.
   - Three `pop` pulses spaced 3 cycles apart.
   - Outputs 5, 9, 12 in order; `pop_cnt`=3; `order_err`=0.
2. **Backpressure:** `out_ready`=0, 6 records available.
   - Exactly 4 pops, then `pop` stays 0.
   - Release `out_ready`: the remaining 2 are popped and all 6 are delivered in order.
3. **Order check:**
   - Pops yield keys 10 then 7 with no `push_seen` → `order_err`=1 after the second pop.
   - Repeat with `push_seen` pulsed between the pops → `order_err` stays 0.
4. **Drain request:** `enable`=0, pulse `drain_req` with 2 records queued.
   - 2 pops, then `q_empty`=1 and `min_valid`=0.
   - `drain_done` is a single pulse; the block returns to IDLE with `busy`=0.
5. **Holdoff:** keep `min_valid` stuck at 1.
   - No pops occur in the 2 HOLD cycles after each pop.
6. **Reset and wrap:**
   - Assert `rst_b` mid-HOLD with 3 FIFO entries → all outputs return to their reset values next cycle.
   - Preload `pop_cnt`=65535 and pop once → `pop_cnt`=0.
